// File: rtl/mdu_iterative.sv
// Multi-cycle multiply/divide unit for the EX stage.
// Multiplies run through a MUL_LATENCY-deep product pipeline; divides use a
// restoring algorithm on operand magnitudes, one quotient bit per cycle,
// followed by a single sign-fixup cycle.
//
// Handshake: an operation is accepted on a rising edge where
// in_valid && in_ready && !cancel (in_ready is high only in IDLE). A result is
// offered while out_valid is high (DONE) and is consumed on a rising edge where
// out_valid && out_ready. cancel overrides everything: the next edge returns
// to IDLE and any pending or in-flight result is dropped.
module mdu_iterative #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo,
  output logic             busy,
  output logic [1:0]       debug_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(WIDTH + MUL_LATENCY + 2);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH);

  state_t state, state_next;

  logic             accept;
  logic             in_signed;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             div_zero;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] out_hi_r;
  logic [WIDTH-1:0] out_lo_r;
  logic [2*WIDTH-1:0] prod_pipe [MUL_LATENCY];

  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] mul_full;
  logic [WIDTH:0]     shift_in;
  logic [WIDTH:0]     diff;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic sgn);
    return (sgn && v[WIDTH-1]) ? (WIDTH'(0) - v) : v;
  endfunction

  assign in_signed   = ~in_op[0];
  assign accept      = (state == IDLE) && in_valid && !cancel;
  assign in_ready    = (state == IDLE);
  assign busy        = (state != IDLE);
  assign out_valid   = (state == DONE);
  assign out_hi      = out_hi_r;
  assign out_lo      = out_lo_r;
  assign debug_state = state;

  // Full 2W-bit product of the incoming operands, sign- or zero-extended.
  always_comb begin
    ext_a    = in_signed ? {{WIDTH{in_a[WIDTH-1]}}, in_a} : {{WIDTH{1'b0}}, in_a};
    ext_b    = in_signed ? {{WIDTH{in_b[WIDTH-1]}}, in_b} : {{WIDTH{1'b0}}, in_b};
    mul_full = ext_a * ext_b;
    shift_in = {rem, quo[WIDTH-1]};
    diff     = shift_in - {1'b0, mag_b};
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic. A zero divisor spends one cycle in DIV loading its
  // fixed result, which gives it a one-cycle latency.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = in_op[1] ? DIV : MUL;
      MUL:  if (count == MUL_LAST) state_next = DONE;
      DIV:  if (div_zero || count == DIV_LAST) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (cancel) state_next = IDLE;
  end

  // Operand latch, product pipeline, divide iterations and result registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count    <= '0;
      a_reg    <= '0;
      mag_b    <= '0;
      rem      <= '0;
      quo      <= '0;
      div_zero <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      out_hi_r <= '0;
      out_lo_r <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) prod_pipe[i] <= '0;
    end else begin
      if (accept) prod_pipe[0] <= mul_full;
      for (int i = 1; i < MUL_LATENCY; i++) prod_pipe[i] <= prod_pipe[i-1];

      if (cancel || accept)                  count <= '0;
      else if (state == MUL || state == DIV) count <= count + 1'b1;

      if (accept) begin
        a_reg    <= in_a;
        mag_b    <= magnitude(in_b, in_signed);
        rem      <= '0;
        quo      <= magnitude(in_a, in_signed);
        div_zero <= in_op[1] && (in_b == '0);
        neg_q    <= in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
        neg_r    <= in_signed && in_a[WIDTH-1];
      end

      if (state == DIV && !cancel && !div_zero && count < DIV_LAST) begin
        if (!diff[WIDTH]) begin
          rem <= diff[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem <= shift_in[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b0};
        end
      end

      if (state != DONE && state_next == DONE) begin
        if (state == MUL) begin
          {out_hi_r, out_lo_r} <= prod_pipe[MUL_LATENCY-1];
        end else if (div_zero) begin
          out_lo_r <= '1;
          out_hi_r <= a_reg;
        end else begin
          out_lo_r <= neg_q ? (WIDTH'(0) - quo) : quo;
          out_hi_r <= neg_r ? (WIDTH'(0) - rem) : rem;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed scenarios followed by
// random operations checked against an arithmetic reference model.
module tb_mdu_iterative;

  localparam int W  = 32;
  localparam int ML = 2;

  logic         clk       = 1'b0;
  logic         resetn    = 1'b0;
  logic         in_valid  = 1'b0;
  logic         cancel    = 1'b0;
  logic         out_ready = 1'b0;
  logic [1:0]   in_op     = 2'd0;
  logic [W-1:0] in_a      = '0;
  logic [W-1:0] in_b      = '0;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [W-1:0] out_hi;
  logic [W-1:0] out_lo;
  logic [1:0]   debug_state;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_hi_q[$];
  logic [W-1:0] exp_lo_q[$];

  mdu_iterative #(.WIDTH(W), .MUL_LATENCY(ML)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .cancel     (cancel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_hi     (out_hi),
    .out_lo     (out_lo),
    .busy       (busy),
    .debug_state(debug_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    longint      sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: res = sa * sb;
      2'd1: res = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else        res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  // Issue one operation, measure latency, check the result, hold it for
  // 'hold' cycles, then consume it.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input string tag);
    logic [63:0]  m;
    logic [W-1:0] eh, el;
    int           n, exp_n;
    m = model(op, a, b);
    exp_hi_q.push_back(m[63:32]);
    exp_lo_q.push_back(m[31:0]);
    exp_n = !op[1] ? ML : ((b == 0) ? 1 : W + 1);
    @(negedge clk);
    check($sformatf("%s in_ready", tag), W'(in_ready), W'(1));
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_op    = 2'($urandom);
    in_a     = $urandom;
    in_b     = $urandom;
    check($sformatf("%s busy_after_accept", tag), W'(busy), W'(1));
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s latency", tag), W'(n), W'(exp_n));
    eh = exp_hi_q.pop_front();
    el = exp_lo_q.pop_front();
    check($sformatf("%s out_hi", tag), out_hi, eh);
    check($sformatf("%s out_lo", tag), out_lo, el);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check($sformatf("%s hold_valid", tag), W'(out_valid), W'(1));
      check($sformatf("%s hold_busy", tag), W'(busy), W'(1));
      check($sformatf("%s hold_hi", tag), out_hi, eh);
      check($sformatf("%s hold_lo", tag), out_lo, el);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("%s valid_after_consume", tag), W'(out_valid), W'(0));
    check($sformatf("%s ready_after_consume", tag), W'(in_ready), W'(1));
  endtask

  initial begin
    logic [1:0]   op;
    logic [W-1:0] a, b;

    // Reset.
    #1;
    check("reset in_ready", W'(in_ready), W'(1));
    check("reset out_valid", W'(out_valid), W'(0));
    check("reset busy", W'(busy), W'(0));
    check("reset out_hi", out_hi, '0);
    check("reset out_lo", out_lo, '0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Directed operations.
    run_op(2'd0, 32'hFFFF_FFFE, 32'd3, 5, "mult");
    check("mult const_hi", out_hi, 32'hFFFF_FFFF);
    check("mult const_lo", out_lo, 32'hFFFF_FFFA);
    run_op(2'd1, 32'hFFFF_FFFE, 32'd3, 0, "multu");
    check("multu const_hi", out_hi, 32'h0000_0002);
    check("multu const_lo", out_lo, 32'hFFFF_FFFA);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1, "div_neg");
    check("div_neg const_lo", out_lo, 32'hFFFF_FFFD);
    check("div_neg const_hi", out_hi, 32'hFFFF_FFFF);
    run_op(2'd3, 32'd100, 32'd7, 0, "divu");
    check("divu const_lo", out_lo, 32'd14);
    check("divu const_hi", out_hi, 32'd2);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    check("div_ovf const_lo", out_lo, 32'h8000_0000);
    check("div_ovf const_hi", out_hi, 32'd0);
    run_op(2'd3, 32'h1234_5678, 32'd0, 2, "divu_zero");
    check("divu_zero const_lo", out_lo, 32'hFFFF_FFFF);
    check("divu_zero const_hi", out_hi, 32'h1234_5678);

    // Cancel mid-divide.
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'd2; in_a = 32'd1000; in_b = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel in_ready", W'(in_ready), W'(1));
    check("cancel out_valid", W'(out_valid), W'(0));
    check("cancel busy", W'(busy), W'(0));
    check("cancel hold_hi", out_hi, 32'h1234_5678);
    check("cancel hold_lo", out_lo, 32'hFFFF_FFFF);
    run_op(2'd1, 32'd5, 32'd6, 0, "multu_after_cancel");
    check("multu_after_cancel const_hi", out_hi, 32'd0);
    check("multu_after_cancel const_lo", out_lo, 32'd30);

    // cancel together with in_valid in IDLE: nothing accepted.
    @(negedge clk);
    in_valid = 1'b1; cancel = 1'b1; in_op = 2'd1; in_a = 32'd7; in_b = 32'd7;
    @(negedge clk);
    in_valid = 1'b0; cancel = 1'b0;
    check("cancel_idle in_ready", W'(in_ready), W'(1));
    check("cancel_idle busy", W'(busy), W'(0));
    repeat (3) @(negedge clk);
    check("cancel_idle out_valid", W'(out_valid), W'(0));

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'd3; in_a = 32'h0000_FFFF; in_b = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("async_reset busy", W'(busy), W'(0));
    check("async_reset out_valid", W'(out_valid), W'(0));
    check("async_reset in_ready", W'(in_ready), W'(1));
    check("async_reset out_hi", out_hi, '0);
    check("async_reset out_lo", out_lo, '0);
    @(negedge clk);
    resetn = 1'b1;
    run_op(2'd3, 32'd9, 32'd3, 0, "divu_after_reset");
    check("divu_after_reset const_lo", out_lo, 32'd3);
    check("divu_after_reset const_hi", out_hi, 32'd0);

    // Random operations, biased towards the boundary operands.
    for (int t = 0; t < 40; t++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op(op, a, b, $urandom_range(0, 2), $sformatf("rand%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
